ddr3_rw_arbiter: RTL and testbench

Time-shares the single user command port of the DDR3 memory-interface IP between the frame-write path (write FIFO) and the frame-read path (read FIFO). It issues bursts of BL8 commands and generates wrapping addresses inside the per-direction windows [min, max). It alternates fairly between the two directions and throttles reads so the read FIFO can never overflow. It sits between the two clock-crossing FIFOs and the DDR3 IP, entirely in the DDR3 user-clock domain.

---
 rtl/ddr3_pkg.sv | 13 +
 rtl/ddr3_rw_arbiter_if.sv | 35 +++
 rtl/ddr3_addr_gen.sv | 52 +++++
 rtl/ddr3_rw_arbiter.sv | 132 +++++++++++++
 tb/tb_ddr3_rw_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr3_pkg.sv
// Shared types and constants for the DDR3 read/write arbiter.
// Command codes, arbiter states and address step per beat.
package ddr3_pkg;
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;
  localparam int ADDR_STEP = 8;

  typedef enum logic [1:0] {
    IDLE,
    WR_BURST,
    RD_BURST
  } state_t;
endpackage

// File: rtl/ddr3_rw_arbiter_if.sv
// FIFO-side and DDR3 user-port signals of the arbiter.
// master = arbiter, slave = FIFOs plus DDR3 IP.
interface ddr3_rw_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 10
);
  logic [CNT_W-1:0]  wfifo_rcount;
  logic [DATA_W-1:0] wfifo_dout;
  logic              wfifo_rden;
  logic [CNT_W-1:0]  rfifo_wcount;
  logic              app_rdy;
  logic              app_wdf_rdy;
  logic              app_rd_data_valid;
  logic              app_en;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic [2:0]        app_cmd;
  logic [ADDR_W-1:0] app_addr;
  logic [DATA_W-1:0] app_wdf_data;

  modport master (
    input  wfifo_rcount, wfifo_dout, rfifo_wcount,
    input  app_rdy, app_wdf_rdy, app_rd_data_valid,
    output wfifo_rden, app_en, app_wdf_wren, app_wdf_end,
    output app_cmd, app_addr, app_wdf_data
  );

  modport slave (
    output wfifo_rcount, wfifo_dout, rfifo_wcount,
    output app_rdy, app_wdf_rdy, app_rd_data_valid,
    input  wfifo_rden, app_en, app_wdf_wren, app_wdf_end,
    input  app_cmd, app_addr, app_wdf_data
  );
endinterface

// File: rtl/ddr3_addr_gen.sv
// Per-direction wrapping address, deferred load and beat counter.
// Loads are only applied while the arbiter is idle.
module ddr3_addr_gen
  import ddr3_pkg::*;
#(
  parameter int ADDR_W = 28
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_idle,
  input  logic              i_start,
  input  logic              i_beat,
  input  logic [ADDR_W-1:0] i_min,
  input  logic [ADDR_W-1:0] i_max,
  input  logic [7:0]        i_len,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_inc;
  logic              r_pend;
  logic [7:0]        r_cnt;
  logic [7:0]        r_len;

  assign w_inc  = r_addr + ADDR_W'(ADDR_STEP);
  assign o_addr = r_addr;
  assign o_last = i_beat && (r_cnt + 8'd1 == r_len);

  // Pending load survives a burst and lands at the next idle cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr <= '0;
      r_pend <= 1'b1;
      r_cnt  <= '0;
      r_len  <= '0;
    end else if (i_idle) begin
      if (r_pend || i_load) r_addr <= i_min;
      r_pend <= 1'b0;
      if (i_start) begin
        r_cnt <= '0;
        r_len <= i_len;
      end
    end else begin
      r_pend <= r_pend | i_load;
      if (i_beat) begin
        r_addr <= (w_inc >= i_max) ? i_min : w_inc;
        r_cnt  <= r_cnt + 8'd1;
      end
    end
  end
endmodule

// File: rtl/ddr3_rw_arbiter.sv
// Shares the DDR3 user command port between write and read bursts.
// Alternates fairly and keeps reads within read-FIFO headroom.
module ddr3_rw_arbiter
  import ddr3_pkg::*;
#(
  parameter int ADDR_W      = 28,
  parameter int DATA_W      = 128,
  parameter int CNT_W       = 10,
  parameter int RFIFO_DEPTH = 512
) (
  input  logic              ui_clk,
  input  logic              ui_clk_sync_rst,
  input  logic              init_calib_complete,
  input  logic              wr_load,
  input  logic              rd_load,
  input  logic [ADDR_W-1:0] app_addr_wr_min,
  input  logic [ADDR_W-1:0] app_addr_wr_max,
  input  logic [ADDR_W-1:0] app_addr_rd_min,
  input  logic [ADDR_W-1:0] app_addr_rd_max,
  input  logic [7:0]        wr_bust_len,
  input  logic [7:0]        rd_bust_len,
  ddr3_rw_arbiter_if.master ddr,
  output logic              busy,
  output logic              wr_done,
  output logic              rd_done
);
  localparam int NW = CNT_W + 2;
  localparam logic [CNT_W:0] ONE = 1;

  state_t            r_state, w_next;
  logic              r_last_wr;
  logic [CNT_W:0]    r_outst;
  logic [NW-1:0]     w_rd_need;
  logic              w_wr_req, w_rd_req, w_idle;
  logic              w_wr_start, w_rd_start;
  logic              w_wr_beat, w_rd_beat;
  logic              w_wr_last, w_rd_last;
  logic [ADDR_W-1:0] w_wr_addr, w_rd_addr;

  assign w_idle    = (r_state == IDLE);
  assign w_rd_need = NW'(ddr.rfifo_wcount) + NW'(r_outst)
                   + NW'(rd_bust_len);
  assign w_wr_req  = init_calib_complete && (wr_bust_len != 8'd0)
                   && (NW'(ddr.wfifo_rcount) >= NW'(wr_bust_len));
  assign w_rd_req  = init_calib_complete && (rd_bust_len != 8'd0)
                   && (w_rd_need <= NW'(RFIFO_DEPTH));
  assign w_wr_beat = (r_state == WR_BURST)
                   && ddr.app_rdy && ddr.app_wdf_rdy;
  assign w_rd_beat = (r_state == RD_BURST) && ddr.app_rdy;
  assign busy      = !w_idle;
  assign ddr.app_wdf_data = ddr.wfifo_dout;

  ddr3_addr_gen #(.ADDR_W(ADDR_W)) u_wr_gen (
    .i_clk(ui_clk), .i_rst(ui_clk_sync_rst),
    .i_load(wr_load), .i_idle(w_idle),
    .i_start(w_wr_start), .i_beat(w_wr_beat),
    .i_min(app_addr_wr_min), .i_max(app_addr_wr_max),
    .i_len(wr_bust_len),
    .o_addr(w_wr_addr), .o_last(w_wr_last)
  );

  ddr3_addr_gen #(.ADDR_W(ADDR_W)) u_rd_gen (
    .i_clk(ui_clk), .i_rst(ui_clk_sync_rst),
    .i_load(rd_load), .i_idle(w_idle),
    .i_start(w_rd_start), .i_beat(w_rd_beat),
    .i_min(app_addr_rd_min), .i_max(app_addr_rd_max),
    .i_len(rd_bust_len),
    .o_addr(w_rd_addr), .o_last(w_rd_last)
  );

  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) r_state <= IDLE;
    else                 r_state <= w_next;
  end

  always_comb begin
    w_next           = r_state;
    w_wr_start       = 1'b0;
    w_rd_start       = 1'b0;
    ddr.app_en       = 1'b0;
    ddr.app_wdf_wren = 1'b0;
    ddr.app_wdf_end  = 1'b0;
    ddr.wfifo_rden   = 1'b0;
    ddr.app_cmd      = CMD_WR;
    ddr.app_addr     = '0;
    wr_done          = 1'b0;
    rd_done          = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_wr_req && (!w_rd_req || !r_last_wr)) begin
          w_wr_start = 1'b1;
          w_next     = WR_BURST;
        end else if (w_rd_req) begin
          w_rd_start = 1'b1;
          w_next     = RD_BURST;
        end
      end
      WR_BURST: begin
        ddr.app_en       = w_wr_beat;
        ddr.app_wdf_wren = w_wr_beat;
        ddr.app_wdf_end  = w_wr_beat;
        ddr.wfifo_rden   = w_wr_beat;
        ddr.app_addr     = w_wr_addr;
        wr_done          = w_wr_last;
        if (w_wr_last) w_next = IDLE;
      end
      RD_BURST: begin
        ddr.app_en   = w_rd_beat;
        ddr.app_cmd  = CMD_RD;
        ddr.app_addr = w_rd_addr;
        rd_done      = w_rd_last;
        if (w_rd_last) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Outstanding reads count toward read-FIFO occupancy until returned.
  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      r_outst   <= '0;
      r_last_wr <= 1'b0;
    end else begin
      if (w_rd_beat && !ddr.app_rd_data_valid)
        r_outst <= r_outst + ONE;
      else if (!w_rd_beat && ddr.app_rd_data_valid && r_outst != '0)
        r_outst <= r_outst - ONE;
      if (w_wr_last)      r_last_wr <= 1'b1;
      else if (w_rd_last) r_last_wr <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// Directed and randomized checks of ddr3_rw_arbiter against a
// transaction-level model of bursts, windows, fairness and throttle.
module tb_ddr3_rw_arbiter;
  import ddr3_pkg::*;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int CW = 10;
  localparam int DEPTH = 512;

  logic clk = 1'b0;
  logic rst;
  logic calib, wr_load, rd_load;
  logic [AW-1:0] wmin, wmax, rmin, rmax;
  logic [7:0] wlen, rlen;
  logic busy, wr_done, rd_done;

  ddr3_rw_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus ();

  ddr3_rw_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .RFIFO_DEPTH(DEPTH)
  ) dut (
    .ui_clk(clk),
    .ui_clk_sync_rst(rst),
    .init_calib_complete(calib),
    .wr_load(wr_load),
    .rd_load(rd_load),
    .app_addr_wr_min(wmin),
    .app_addr_wr_max(wmax),
    .app_addr_rd_min(rmin),
    .app_addr_rd_max(rmax),
    .wr_bust_len(wlen),
    .rd_bust_len(rlen),
    .ddr(bus),
    .busy(busy),
    .wr_done(wr_done),
    .rd_done(rd_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model: busy flag, direction, beats done, burst length, addresses
  int m_busy, m_wr, m_cnt, m_len, m_wa, m_ra, m_out;
  bit m_wp, m_rp, m_lastw;

  // observations from the DUT
  int acc_a[$];
  int acc_c[$];
  int obs_g[$];
  int n_wd;
  bit prev_busy;

  task automatic chk(string tag, logic [DW-1:0] obs,
                     logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    acc_a.delete();
    acc_c.delete();
    obs_g.delete();
    n_wd = 0;
  endtask

  task automatic tick();
    bit en, wq, rq, rd_acc;
    int ea;
    @(negedge clk);
    en = 1'b0;
    if (m_busy != 0)
      en = m_wr != 0 ? (bus.app_rdy && bus.app_wdf_rdy) : bus.app_rdy;
    ea = (m_busy == 0) ? 0 : (m_wr != 0 ? m_wa : m_ra);
    chk("busy", busy, m_busy != 0);
    chk("app_en", bus.app_en, en);
    chk("wfifo_rden", bus.wfifo_rden, en && m_wr != 0);
    chk("app_wdf_wren", bus.app_wdf_wren, en && m_wr != 0);
    chk("app_wdf_end", bus.app_wdf_end, en && m_wr != 0);
    chk("app_cmd", bus.app_cmd,
        (m_busy != 0 && m_wr == 0) ? CMD_RD : CMD_WR);
    chk("app_addr", bus.app_addr, ea);
    chk("wr_done", wr_done,
        en && m_wr != 0 && (m_cnt + 1 == m_len));
    chk("rd_done", rd_done,
        en && m_wr == 0 && (m_cnt + 1 == m_len));
    chk("app_wdf_data", bus.app_wdf_data, bus.wfifo_dout);
    if (busy && !prev_busy) obs_g.push_back(bus.app_cmd == CMD_WR);
    prev_busy = busy;
    if (bus.app_en) begin
      acc_a.push_back(int'(bus.app_addr));
      acc_c.push_back(int'(bus.app_cmd));
    end
    if (wr_done) n_wd++;
    if (m_busy == 0) begin
      if (m_wp || wr_load) m_wa = int'(wmin);
      if (m_rp || rd_load) m_ra = int'(rmin);
      m_wp = 1'b0;
      m_rp = 1'b0;
      wq = calib && wlen != 0 && bus.wfifo_rcount >= wlen;
      rq = calib && rlen != 0 &&
           (int'(bus.rfifo_wcount) + m_out + int'(rlen) <= DEPTH);
      if (wq || rq) begin
        m_busy = 1;
        m_wr   = (wq && (!rq || !m_lastw)) ? 1 : 0;
        m_cnt  = 0;
        m_len  = m_wr != 0 ? int'(wlen) : int'(rlen);
      end
    end else begin
      m_wp |= wr_load;
      m_rp |= rd_load;
      if (en) begin
        if (m_wr != 0) begin
          m_wa += ADDR_STEP;
          if (m_wa >= int'(wmax)) m_wa = int'(wmin);
        end else begin
          m_ra += ADDR_STEP;
          if (m_ra >= int'(rmax)) m_ra = int'(rmin);
        end
        m_cnt++;
        if (m_cnt == m_len) begin
          m_busy  = 0;
          m_lastw = m_wr != 0;
        end
      end
    end
    rd_acc = en && m_wr == 0;
    if (rd_acc && !bus.app_rd_data_valid) m_out++;
    else if (!rd_acc && bus.app_rd_data_valid && m_out > 0) m_out--;
    @(posedge clk);
    #1;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_app_en", bus.app_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wfifo_rden", bus.wfifo_rden, 0);
    chk("rst_app_wdf_wren", bus.app_wdf_wren, 0);
    chk("rst_app_addr", bus.app_addr, 0);
    chk("rst_app_cmd", bus.app_cmd, 0);
    chk("rst_wr_done", wr_done, 0);
    chk("rst_rd_done", rd_done, 0);
    m_busy = 0; m_wr = 0; m_cnt = 0; m_len = 0;
    m_wa = 0; m_ra = 0; m_out = 0;
    m_wp = 1'b1; m_rp = 1'b1; m_lastw = 1'b0;
    prev_busy = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_obs();
  endtask

  initial begin
    rst = 1'b1;
    calib = 1'b0; wr_load = 1'b0; rd_load = 1'b0;
    wmin = 0; wmax = 'h40; rmin = 'h200; rmax = 'h400;
    wlen = 0; rlen = 0;
    bus.wfifo_rcount = 0; bus.rfifo_wcount = 0;
    bus.wfifo_dout = {4{$urandom}};
    bus.app_rdy = 1'b1; bus.app_wdf_rdy = 1'b1;
    bus.app_rd_data_valid = 1'b0;
    do_reset();

    // write only, four beats
    calib = 1'b1; wlen = 4; bus.wfifo_rcount = 8;
    tick();
    bus.wfifo_rcount = 0;
    run(6);
    chk("wo_beats", acc_a.size(), 4);
    if (acc_a.size() == 4) begin
      chk("wo_a0", acc_a[0], 'h0);
      chk("wo_a1", acc_a[1], 'h8);
      chk("wo_a2", acc_a[2], 'h10);
      chk("wo_a3", acc_a[3], 'h18);
    end
    chk("wo_done_cnt", n_wd, 1);

    // wrap inside a small window
    clear_obs();
    wmin = 'h100; wmax = 'h120; wlen = 8;
    wr_load = 1'b1; bus.wfifo_rcount = 8;
    tick();
    wr_load = 1'b0; bus.wfifo_rcount = 0;
    run(10);
    chk("wrap_beats", acc_a.size(), 8);
    for (int i = 0; i < 8 && i < acc_a.size(); i++)
      chk($sformatf("wrap_a%0d", i), acc_a[i], 'h100 + 8 * (i % 4));

    // fair alternation, write first after reset
    do_reset();
    wmin = 0; wmax = 'h1000; wlen = 2; rlen = 2;
    bus.wfifo_rcount = 100; bus.rfifo_wcount = 0;
    run(16);
    chk("alt_grants", obs_g.size() >= 4, 1);
    if (obs_g.size() >= 4) begin
      chk("alt_g0", obs_g[0], 1);
      chk("alt_g1", obs_g[1], 0);
      chk("alt_g2", obs_g[2], 1);
      chk("alt_g3", obs_g[3], 0);
    end

    // read throttle at the FIFO limit
    do_reset();
    wlen = 0; rlen = 8; bus.wfifo_rcount = 0;
    bus.rfifo_wcount = 508;
    run(10);
    chk("thr_no_grant", obs_g.size(), 0);
    bus.rfifo_wcount = 504;
    run(3);
    bus.rfifo_wcount = 508;
    chk("thr_grant", obs_g.size(), 1);
    if (obs_g.size() == 1) chk("thr_dir", obs_g[0], 0);
    if (acc_a.size() > 0) begin
      chk("thr_a0", acc_a[0], 'h200);
      chk("thr_c0", acc_c[0], CMD_RD);
    end
    run(8);

    // backpressure on beat 2
    do_reset();
    rlen = 0; wmin = 'h40; wlen = 4; bus.wfifo_rcount = 4;
    tick();
    bus.wfifo_rcount = 0;
    tick();
    bus.app_rdy = 1'b0;
    run(3);
    bus.app_rdy = 1'b1;
    run(5);
    chk("bp_beats", acc_a.size(), 4);
    for (int i = 0; i < 4 && i < acc_a.size(); i++)
      chk($sformatf("bp_a%0d", i), acc_a[i], 'h40 + 8 * i);
    chk("bp_done_cnt", n_wd, 1);

    // load mid-burst, then reset mid-burst
    clear_obs();
    bus.wfifo_rcount = 4;
    tick();
    tick();
    wr_load = 1'b1;
    tick();
    wr_load = 1'b0;
    run(5);
    chk("ld_beats", acc_a.size(), 6);
    if (acc_a.size() == 6) begin
      chk("ld_a3", acc_a[3], 'h78);
      chk("ld_a4", acc_a[4], 'h40);
      chk("ld_a5", acc_a[5], 'h48);
    end
    chk("pre_rst_busy", busy, 1);
    do_reset();

    // randomized traffic
    wmin = 'h1000; wmax = 'h1000 + 8 * $urandom_range(1, 20);
    rmin = 'h8000; rmax = 'h8000 + 8 * $urandom_range(1, 20);
    for (int i = 0; i < 3000; i++) begin
      calib = ($urandom % 16) != 0;
      wlen = 8'($urandom % 6);
      rlen = 8'($urandom % 6);
      wr_load = ($urandom % 20) == 0;
      rd_load = ($urandom % 20) == 0;
      bus.wfifo_rcount = 10'($urandom % 16);
      bus.rfifo_wcount = 10'(490 + $urandom % 23);
      bus.wfifo_dout = {4{$urandom}};
      bus.app_rdy = ($urandom % 4) != 0;
      bus.app_wdf_rdy = ($urandom % 4) != 0;
      bus.app_rd_data_valid = $urandom % 2;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
